// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Port index enum and burst counter width.
package cpu_types;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } mem_port_t;

    localparam int MEM_ARB_BURST_W = 8;

endpackage

// File: rtl/mem_arb_stats.sv
// Grant and wait statistics for mem_arbiter.
// Counters wrap modulo 2^32; cleared by synchronous reset.
module mem_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        ready0,
    input  logic        ready1,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1,
    output logic [31:0] wait_cnt
);

    logic [31:0] grant_cnt0_q, grant_cnt0_d;
    logic [31:0] grant_cnt1_q, grant_cnt1_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        waiting;

    // Next counter values: one grant per port, one wait per stalled cycle.
    always_comb begin
        waiting      = (req0 & ~ready0) | (req1 & ~ready1);
        grant_cnt0_d = grant_cnt0_q + {31'd0, ready0};
        grant_cnt1_d = grant_cnt1_q + {31'd0, ready1};
        wait_cnt_d   = wait_cnt_q + {31'd0, waiting};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign wait_cnt   = wait_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port zero-latency memory arbiter: round-robin with bounded lock bursts.
// Optional statistics counters enabled by macro MEM_ARB_STATS_EN.
module mem_arbiter
    import cpu_types::*;
#(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    input  logic              we0,
    input  logic              we1,
    output logic              ready0,
    output logic              ready1,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] memory_address,
    output logic [31:0]       memory_write,
    output logic [3:0]        memory_byte_enable,
    output logic              memory_we,
    input  logic [31:0]       memory_out,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       wait_cnt
);

    localparam logic [MEM_ARB_BURST_W-1:0] BURST_LIM =
        MEM_ARB_BURST_W'(MAX_BURST - 1);

    mem_port_t                  last_q, last_d;
    mem_port_t                  owner_q, owner_d;
    logic                       owner_valid_q, owner_valid_d;
    logic [MEM_ARB_BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic      own_req;
    logic      own_lock;
    logic      lock_hold;
    logic      grant_valid;
    mem_port_t grant_port;
    logic      grant_lock;

    // Arbitration decision and RAM-side mux, purely combinational.
    always_comb begin
        own_req     = (owner_q == PORT_AUX) ? req1 : req0;
        own_lock    = (owner_q == PORT_AUX) ? lock1 : lock0;
        lock_hold   = owner_valid_q & own_req & own_lock &
                      (burst_cnt_q < BURST_LIM);
        grant_valid = 1'b0;
        grant_port  = PORT_CPU;
        if (!rst) begin
            if (lock_hold) begin
                grant_valid = 1'b1;
                grant_port  = owner_q;
            end else if (req0 && req1) begin
                grant_valid = 1'b1;
                grant_port  = (last_q == PORT_CPU) ? PORT_AUX : PORT_CPU;
            end else if (req0) begin
                grant_valid = 1'b1;
                grant_port  = PORT_CPU;
            end else if (req1) begin
                grant_valid = 1'b1;
                grant_port  = PORT_AUX;
            end
        end
        grant_lock = (grant_port == PORT_AUX) ? lock1 : lock0;

        ready0             = grant_valid & (grant_port == PORT_CPU);
        ready1             = grant_valid & (grant_port == PORT_AUX);
        memory_address     = '0;
        memory_write       = '0;
        memory_byte_enable = '0;
        memory_we          = 1'b0;
        if (ready0) begin
            memory_address     = addr0;
            memory_write       = wdata0;
            memory_byte_enable = be0;
            memory_we          = we0;
        end else if (ready1) begin
            memory_address     = addr1;
            memory_write       = wdata1;
            memory_byte_enable = be1;
            memory_we          = we1;
        end
        rdata = memory_out;
    end

    // Next ownership / round-robin state.
    always_comb begin
        last_d        = last_q;
        owner_d       = owner_q;
        owner_valid_d = 1'b0;
        burst_cnt_d   = '0;
        if (grant_valid) begin
            last_d        = grant_port;
            owner_d       = grant_port;
            owner_valid_d = grant_lock;
            burst_cnt_d   = lock_hold ? burst_cnt_q + 1'b1 : '0;
        end
    end

    // State registers; port 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q        <= PORT_AUX;
            owner_q       <= PORT_CPU;
            owner_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
        end else begin
            last_q        <= last_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .ready0     (ready0),
        .ready1     (ready1),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .wait_cnt   (wait_cnt)
    );
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
    assign wait_cnt   = '0;
`endif

endmodule
